// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute phase controller: owns pc and ir, fetches opcodes over req/ack.
// Optional SINGLE_STEP_EN adds a step input and halts after every instruction.
module instruction_sequencer #(
  parameter int unsigned           ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [7:0]        ir,
  output logic              fetch,
  output logic              decode,
  output logic              execute,
  input  logic              exec_stall,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              halt_req,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExecute, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              fetch_q, decode_q, execute_q, halted_q;
  logic              resume;

`ifdef SINGLE_STEP_EN
  assign resume = (run && !halt_req) || step;
`else
  assign resume = run && !halt_req;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        // Jump and halt are only honoured on the last execute cycle.
        if (!exec_stall) begin
          if (pc_load) pc_d = pc_load_val;
`ifdef SINGLE_STEP_EN
          state_d = StHalt;
`else
          state_d = halt_req ? StHalt : StFetch;
`endif
        end
      end
      StHalt: begin
        if (resume) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      fetch_q   <= 1'b0;
      decode_q  <= 1'b0;
      execute_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      fetch_q   <= (state_d == StFetch);
      decode_q  <= (state_d == StDecode);
      execute_q <= (state_d == StExecute);
      halted_q  <= (state_d == StHalt);
    end
  end

  assign mem_req  = fetch_q;
  assign fetch    = fetch_q;
  assign decode   = decode_q;
  assign execute  = execute_q;
  assign halted   = halted_q;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Table-driven bench for instruction_sequencer plus hand sequences for reset and single-step.
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, mem_ack, exec_stall, pc_load, halt_req;
  logic [7:0] mem_data, pc_load_val;
  logic       mem_req, fetch, decode, execute, halted;
  logic [7:0] mem_addr, ir, pc;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.ADDR_W(8), .RESET_PC(8'h10)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .ir          (ir),
    .fetch       (fetch),
    .decode      (decode),
    .execute     (execute),
    .exec_stall  (exec_stall),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .halt_req    (halt_req),
    .halted      (halted),
    .pc          (pc)
  );

  typedef struct packed {
    logic       run, ack;
    logic [7:0] data;
    logic       stall, ld;
    logic [7:0] ldv;
    logic       hreq;
    logic       f, d, x, h;
    logic [7:0] pc, ir;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic f, input logic d, input logic x,
                         input logic h, input logic [7:0] epc, input logic [7:0] eir);
    chk({nm, " fetch"}, 32'(fetch), 32'(f));
    chk({nm, " mem_req"}, 32'(mem_req), 32'(f));
    chk({nm, " decode"}, 32'(decode), 32'(d));
    chk({nm, " execute"}, 32'(execute), 32'(x));
    chk({nm, " halted"}, 32'(halted), 32'(h));
    chk({nm, " pc"}, 32'(pc), 32'(epc));
    chk({nm, " mem_addr"}, 32'(mem_addr), 32'(epc));
    chk({nm, " ir"}, 32'(ir), 32'(eir));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          run ack data  stl ld ldv   hrq f d x h pc     ir
    vecs[0]  = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b1000, 8'h10, 8'h00};
    vecs[1]  = {1'b1, 1'b1, 8'h3A, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0100, 8'h11, 8'h3A};
    vecs[2]  = {1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0010, 8'h11, 8'h3A};
    vecs[3]  = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b1000, 8'h11, 8'h3A};
    vecs[4]  = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b1000, 8'h11, 8'h3A};
    vecs[5]  = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b1000, 8'h11, 8'h3A};
    vecs[6]  = {1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0100, 8'h12, 8'h55};
    vecs[7]  = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0010, 8'h12, 8'h55};
    vecs[8]  = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0010, 8'h12, 8'h55};
    vecs[9]  = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0010, 8'h12, 8'h55};
    vecs[10] = {1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b1, 4'b0010, 8'h12, 8'h55};
    vecs[11] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 4'b1000, 8'h80, 8'h55};
    vecs[12] = {1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0100, 8'h81, 8'hC3};
    vecs[13] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 4'b0010, 8'h81, 8'hC3};
    vecs[14] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 4'b1000, 8'hFF, 8'hC3};
    vecs[15] = {1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0100, 8'h00, 8'h11};
    vecs[16] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0010, 8'h00, 8'h11};
    vecs[17] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b1, 4'b0001, 8'h44, 8'h11};
    vecs[18] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 4'b0001, 8'h44, 8'h11};
    vecs[19] = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0001, 8'h44, 8'h11};
    vecs[20] = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b1000, 8'h44, 8'h11};

    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = 8'h00; exec_stall = 1'b0;
    pc_load = 1'b0; pc_load_val = 8'h00; halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);

`ifndef SINGLE_STEP_EN
    for (int i = 0; i < 21; i++) begin
      run = vecs[i].run; mem_ack = vecs[i].ack; mem_data = vecs[i].data;
      exec_stall = vecs[i].stall; pc_load = vecs[i].ld; pc_load_val = vecs[i].ldv;
      halt_req = vecs[i].hreq;
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].f, vecs[i].d, vecs[i].x, vecs[i].h,
              vecs[i].pc, vecs[i].ir);
    end
    pc_load = 1'b0; halt_req = 1'b0;

    // Fetch at 0x44, then reset asynchronously while stalled in execute.
    mem_ack = 1'b1; mem_data = 8'h77;
    tick();
    chk_all("r_dec", 1'b0, 1'b1, 1'b0, 1'b0, 8'h45, 8'h77);
    mem_ack = 1'b0; exec_stall = 1'b1;
    tick();
    tick();
    chk_all("r_exec", 1'b0, 1'b0, 1'b1, 1'b0, 8'h45, 8'h77);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    tick();
    rst = 1'b0; exec_stall = 1'b0; run = 1'b0;
    tick();
    chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
`else
    run = 1'b1;
    tick();
    chk_all("s_f1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    run = 1'b0; mem_ack = 1'b1; mem_data = 8'hA5;
    tick();
    chk_all("s_d1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'hA5);
    mem_ack = 1'b0;
    tick();
    chk_all("s_x1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 8'hA5);
    tick();
    chk_all("s_h1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'hA5);
    tick();
    chk_all("s_h1b", 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'hA5);
    step = 1'b1;
    tick();
    chk_all("s_f2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'hA5);
    step = 1'b0; mem_ack = 1'b1; mem_data = 8'h5A;
    tick();
    chk_all("s_d2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h5A);
    mem_ack = 1'b0;
    tick();
    chk_all("s_x2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h5A);
    tick();
    chk_all("s_h2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h5A);
    tick();
    chk_all("s_h2b", 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
